// File: rtl/transfer_ctrl_if.sv
// transfer_ctrl_if: command handshake plus register-file / shared-bus control lines.
interface transfer_ctrl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [4:0] cmd_addr;
   logic [4:0] DataA;
   logic [4:0] DataB;
   logic       SEL_A;
   logic       SEL_B;
   logic       LD_A;
   logic       LD_B;
   logic       OEA;
   logic       OEB;
   logic       busy;
   logic       done;

   // Command source side: offers commands, observes the controller.
   modport master (
      output cmd_valid, cmd_op, cmd_addr,
      input  cmd_ready, DataA, DataB, SEL_A, SEL_B, LD_A, LD_B, OEA, OEB, busy, done
   );

   // Controller side: accepts commands, drives register and bus controls.
   modport slave (
      input  cmd_valid, cmd_op, cmd_addr,
      output cmd_ready, DataA, DataB, SEL_A, SEL_B, LD_A, LD_B, OEA, OEB, busy, done
   );
endinterface

// File: rtl/transfer_ctrl.sv
// transfer_ctrl: queues register-transfer commands and sequences the file-register
// read path and the shared tristate bus between registers A and B.
module transfer_ctrl #(
   parameter int CMD_DEPTH = 4,   // power of 2, >= 2
   parameter int RD_LAT    = 0,   // 0..3 file-register wait cycles before load
   parameter int TURN_CYC  = 1    // 1..3 bus-idle cycles after each drive
) (
   input  logic           clk,
   input  logic           rst,
   transfer_ctrl_if.slave bus
);

   localparam int PTR_W = $clog2(CMD_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      LOAD_A  = 2'd0,
      LOAD_B  = 2'd1,
      MOVE_AB = 2'd2,
      MOVE_BA = 2'd3
   } op_t;

   typedef enum logic [2:0] {IDLE, RDWAIT, LOAD, DRIVE, XFER, TURN} state_t;

   typedef struct packed {
      op_t        op;
      logic [4:0] addr;
   } cmd_t;

   typedef struct packed {
      logic [4:0] data_a;
      logic [4:0] data_b;
      logic       sel_a;
      logic       sel_b;
      logic       ld_a;
      logic       ld_b;
      logic       oea;
      logic       oeb;
      logic       done;
   } ctl_t;

   cmd_t             mem [CMD_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   cmd_t             head;
   cmd_t             cur;
   state_t           state;
   logic [1:0]       wait_cnt;
   logic [1:0]       turn_cnt;
   ctl_t             ctl;

   assign full  = (count == CNT_W'(CMD_DEPTH));
   assign empty = (count == '0);
   // A pop in the same cycle never opens the FIFO early: ready follows full only.
   assign push  = bus.cmd_valid && !full;
   assign pop   = (state == IDLE) && !empty;
   assign head  = mem[rd_ptr];

   // Control word for a given state and command; fin marks the final TURN cycle.
   function automatic ctl_t ctl_for(input state_t s, input cmd_t c, input logic fin);
      ctl_t o;
      // NOTE: every field gets a default before the case, so no path leaves an output
      // unassigned (in combinational code that would infer a latch).
      o = '0;
      case (s)
         RDWAIT, LOAD: begin
            if (c.op == LOAD_A) begin
               o.data_a = c.addr;
               o.sel_a  = 1'b1;
               o.ld_a   = (s == LOAD);
            end else if (c.op == LOAD_B) begin
               o.data_b = c.addr;
               o.sel_b  = 1'b1;
               o.ld_b   = (s == LOAD);
            end
            o.done = (s == LOAD);
         end
         DRIVE, XFER: begin
            // The receiving register's select stays 0 so it takes the shared bus.
            if (c.op == MOVE_AB) begin
               o.oea  = 1'b1;
               o.ld_b = (s == XFER);
            end else if (c.op == MOVE_BA) begin
               o.oeb  = 1'b1;
               o.ld_a = (s == XFER);
            end
         end
         TURN:    o.done = fin;
         default: ;
      endcase
      return o;
   endfunction

   // NOTE: the command storage has no reset; count alone says which slots hold valid
   // data, so clearing the array would only cost reset fan-out.
   // Command storage write port.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{op: op_t'(bus.cmd_op), addr: bus.cmd_addr};
   end

   // FIFO pointers and occupancy; pointers wrap naturally at CMD_DEPTH.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Command sequencer with registered control outputs computed for the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cur      <= '0;
         wait_cnt <= '0;
         turn_cnt <= '0;
         ctl      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  cur <= head;
                  if (head.op == LOAD_A || head.op == LOAD_B) begin
                     if (RD_LAT == 0) begin
                        state <= LOAD;
                        ctl   <= ctl_for(LOAD, head, 1'b0);
                     end else begin
                        state    <= RDWAIT;
                        wait_cnt <= 2'(RD_LAT - 1);
                        ctl      <= ctl_for(RDWAIT, head, 1'b0);
                     end
                  end else begin
                     state <= DRIVE;
                     ctl   <= ctl_for(DRIVE, head, 1'b0);
                  end
               end
            end
            RDWAIT: begin
               if (wait_cnt == 2'd0) begin
                  state <= LOAD;
                  ctl   <= ctl_for(LOAD, cur, 1'b0);
               end else begin
                  wait_cnt <= wait_cnt - 2'd1;
               end
            end
            LOAD: begin
               state <= IDLE;
               ctl   <= '0;
            end
            DRIVE: begin
               state <= XFER;
               ctl   <= ctl_for(XFER, cur, 1'b0);
            end
            XFER: begin
               state    <= TURN;
               turn_cnt <= 2'(TURN_CYC - 1);
               ctl      <= ctl_for(TURN, cur, TURN_CYC == 1);
            end
            TURN: begin
               if (turn_cnt == 2'd0) begin
                  state <= IDLE;
                  ctl   <= '0;
               end else begin
                  turn_cnt <= turn_cnt - 2'd1;
                  ctl      <= ctl_for(TURN, cur, turn_cnt == 2'd1);
               end
            end
            default: begin
               state <= IDLE;
               ctl   <= '0;
            end
         endcase
      end
   end

   assign bus.cmd_ready = !full;
   assign bus.busy      = (state != IDLE) || !empty;
   assign bus.DataA     = ctl.data_a;
   assign bus.DataB     = ctl.data_b;
   assign bus.SEL_A     = ctl.sel_a;
   assign bus.SEL_B     = ctl.sel_b;
   assign bus.LD_A      = ctl.ld_a;
   assign bus.LD_B      = ctl.ld_b;
   assign bus.OEA       = ctl.oea;
   assign bus.OEB       = ctl.oeb;
   assign bus.done      = ctl.done;

endmodule

// File: tb/tb_transfer_ctrl.sv
// tb_transfer_ctrl: two controllers (RD_LAT=0/TURN_CYC=1 and RD_LAT=2/TURN_CYC=2)
// receive the same command list; a schedule model predicts every cycle of each.
module tb_transfer_ctrl;
   localparam int DEPTH = 4;
   localparam int RDL0  = 0;
   localparam int RDL1  = 2;
   localparam int TRN0  = 1;
   localparam int TRN1  = 2;
   localparam logic [1:0] OP_LA = 2'd0, OP_LB = 2'd1, OP_AB = 2'd2, OP_BA = 2'd3;

   // One accepted command: accept edge e, first active cycle s, last (done) cycle f.
   typedef struct {
      int         d;
      logic [1:0] op;
      logic [4:0] addr;
      int         e;
      int         s;
      int         f;
   } rec_t;

   typedef struct packed {
      logic [1:0] op;
      logic [4:0] addr;
   } cmd_t;

   typedef struct packed {
      logic [4:0] data_a;
      logic [4:0] data_b;
      logic       sel_a;
      logic       sel_b;
      logic       ld_a;
      logic       ld_b;
      logic       oea;
      logic       oeb;
      logic       done;
      logic       busy;
      logic       ready;
   } obs_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   transfer_ctrl_if if0 ();
   transfer_ctrl_if if1 ();

   transfer_ctrl #(.CMD_DEPTH(DEPTH), .RD_LAT(RDL0), .TURN_CYC(TRN0)) dut0 (
      .clk(clk), .rst(rst), .bus(if0)
   );
   transfer_ctrl #(.CMD_DEPTH(DEPTH), .RD_LAT(RDL1), .TURN_CYC(TRN1)) dut1 (
      .clk(clk), .rst(rst), .bus(if1)
   );

   logic       vld [2];
   logic [1:0] opd [2];
   logic [4:0] adr [2];

   assign if0.cmd_valid = vld[0];
   assign if0.cmd_op    = opd[0];
   assign if0.cmd_addr  = adr[0];
   assign if1.cmd_valid = vld[1];
   assign if1.cmd_op    = opd[1];
   assign if1.cmd_addr  = adr[1];

   obs_t obs0, obs1;
   assign obs0 = {if0.DataA, if0.DataB, if0.SEL_A, if0.SEL_B, if0.LD_A, if0.LD_B,
                  if0.OEA, if0.OEB, if0.done, if0.busy, if0.cmd_ready};
   assign obs1 = {if1.DataA, if1.DataB, if1.SEL_A, if1.SEL_B, if1.LD_A, if1.LD_B,
                  if1.OEA, if1.OEB, if1.done, if1.busy, if1.cmd_ready};

   rec_t mq [$];
   cmd_t stim [$];
   int   sidx [2];
   int   last_f [2];
   int   last_oe [2];
   logic prev_oe [2];
   int   done_obs [2];
   int   done_exp [2];
   int   cyc;
   int   n_tests;
   int   n_fail;

   function automatic int rdl(input int d);
      return (d == 0) ? RDL0 : RDL1;
   endfunction

   function automatic int trn(input int d);
      return (d == 0) ? TRN0 : TRN1;
   endfunction

   function automatic obs_t get_obs(input int d);
      return (d == 0) ? obs0 : obs1;
   endfunction

   // Commands sitting in the FIFO during cycle c: accepted, not yet started.
   function automatic int occ(input int d, input int c);
      int n = 0;
      foreach (mq[i]) if (mq[i].d == d && mq[i].e <= c && c < mq[i].s) n++;
      return n;
   endfunction

   function automatic logic in_xfer_ba(input int d, input int c);
      foreach (mq[i]) if (mq[i].d == d && mq[i].op == OP_BA && c - mq[i].s == 1) return 1'b1;
      return 1'b0;
   endfunction

   // Expected outputs in cycle c, from the command's offset into its schedule.
   function automatic obs_t expect_at(input int d, input int c);
      obs_t x;
      int   k;
      x       = '0;
      x.ready = (occ(d, c) < DEPTH);
      foreach (mq[i]) begin
         if (mq[i].d == d) begin
            if (mq[i].e <= c && c <= mq[i].f) x.busy = 1'b1;
            if (mq[i].s <= c && c <= mq[i].f) begin
               k = c - mq[i].s;
               case (mq[i].op)
                  OP_LA: begin
                     x.data_a = mq[i].addr;
                     x.sel_a  = 1'b1;
                     x.ld_a   = (k == rdl(d));
                     x.done   = (k == rdl(d));
                  end
                  OP_LB: begin
                     x.data_b = mq[i].addr;
                     x.sel_b  = 1'b1;
                     x.ld_b   = (k == rdl(d));
                     x.done   = (k == rdl(d));
                  end
                  OP_AB: begin
                     x.oea  = (k < 2);
                     x.ld_b = (k == 1);
                     x.done = (k == 1 + trn(d));
                  end
                  default: begin
                     x.oeb  = (k < 2);
                     x.ld_a = (k == 1);
                     x.done = (k == 1 + trn(d));
                  end
               endcase
            end
         end
      end
      return x;
   endfunction

   task automatic check(input string tag, input int d, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s dut%0d cyc %0d: observed %0h expected %0h", tag, d, cyc, got, exp);
      end
   endtask

   task automatic drive();
      for (int d = 0; d < 2; d++) begin
         if (sidx[d] < stim.size()) begin
            vld[d] = 1'b1;
            opd[d] = stim[sidx[d]].op;
            adr[d] = stim[sidx[d]].addr;
         end else begin
            vld[d] = 1'b0;
            opd[d] = 2'($urandom);
            adr[d] = 5'($urandom);
         end
      end
   endtask

   task automatic push_cmd(input logic [1:0] op, input logic [4:0] a);
      cmd_t c;
      c.op   = op;
      c.addr = a;
      stim.push_back(c);
      drive();
   endtask

   task automatic accept(input int d, input int e);
      rec_t r;
      cmd_t c;
      c      = stim[sidx[d]];
      r.d    = d;
      r.op   = c.op;
      r.addr = c.addr;
      r.e    = e;
      r.s    = (e + 1 > last_f[d] + 2) ? e + 1 : last_f[d] + 2;
      r.f    = r.s - 1 + ((c.op == OP_LA || c.op == OP_LB) ? rdl(d) + 1 : 2 + trn(d));
      mq.push_back(r);
      last_f[d] = r.f;
      sidx[d]++;
   endtask

   task automatic model_reset();
      mq.delete();
      stim.delete();
      sidx    = '{0, 0};
      last_f  = '{-100, -100};
      last_oe = '{-1, -1};
      prev_oe = '{1'b0, 1'b0};
      drive();
   endtask

   task automatic check_cycle();
      obs_t o;
      obs_t x;
      logic oe;
      for (int d = 0; d < 2; d++) begin
         o = get_obs(d);
         x = expect_at(d, cyc);
         check("ctl",   d, 32'(o[18:2]), 32'(x[18:2]));
         check("busy",  d, 32'(o.busy),  32'(x.busy));
         check("ready", d, 32'(o.ready), 32'(x.ready));
         check("oe_excl", d, 32'(o.oea & o.oeb), 32'd0);
         check("ld_excl", d, 32'(o.ld_a & o.ld_b), 32'd0);
         oe = o.oea | o.oeb;
         if (oe && !prev_oe[d] && last_oe[d] >= 0)
            check("turn_gap", d, 32'((cyc - last_oe[d] - 1) >= trn(d)), 32'd1);
         if (oe) last_oe[d] = cyc;
         prev_oe[d] = oe;
         if (x.done) done_exp[d]++;
         if (o.done) done_obs[d]++;
      end
   endtask

   task automatic check_reset_outputs();
      obs_t o;
      for (int d = 0; d < 2; d++) begin
         o = get_obs(d);
         check("rst_ctl",   d, 32'(o[18:2]), 32'd0);
         check("rst_busy",  d, 32'(o.busy),  32'd0);
         check("rst_ready", d, 32'(o.ready), 32'd1);
      end
   endtask

   // One clock: model acceptance at the edge, then compare on the falling edge.
   task automatic step();
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 2; d++)
         if (rst && vld[d] && occ(d, cyc - 1) < DEPTH) accept(d, cyc);
      @(negedge clk);
      check_cycle();
      drive();
   endtask

   task automatic run_idle(input int budget);
      int n = 0;
      while (!(sidx[0] == stim.size() && sidx[1] == stim.size() &&
               cyc > last_f[0] && cyc > last_f[1]) && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) begin
         n_tests++;
         n_fail++;
         $error("FAIL idle_timeout: observed %0d cycles, required fewer than %0d", n, budget);
      end
      step();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      n_tests  = 0;
      n_fail   = 0;
      cyc      = 0;
      done_obs = '{0, 0};
      done_exp = '{0, 0};

      // Reset state, asserted before any clock edge.
      rst = 1'b0;
      model_reset();
      #1;
      check_reset_outputs();
      step();
      rst = 1'b1;

      // Single LOAD_A, accepted at the first edge after release.
      push_cmd(OP_LA, 5'h0C);
      run_idle(50);

      // Single MOVE_AB.
      push_cmd(OP_AB, 5'h00);
      run_idle(50);

      // Five back-to-back commands against a depth-4 FIFO.
      push_cmd(OP_LB, 5'h03);
      push_cmd(OP_AB, 5'h11);
      push_cmd(OP_LA, 5'h1A);
      push_cmd(OP_BA, 5'h07);
      push_cmd(OP_LB, 5'h15);
      run_idle(200);

      // Alternating bus moves in both directions.
      for (int i = 0; i < 8; i++) push_cmd((i % 2 == 0) ? OP_AB : OP_BA, 5'(i));
      run_idle(300);

      // LOAD_B at the top address.
      push_cmd(OP_LB, 5'h1F);
      run_idle(50);

      // Random traffic with random gaps.
      for (int i = 0; i < 40; i++) begin
         push_cmd(2'($urandom), 5'($urandom));
         n = int'($urandom_range(0, 3));
         for (int j = 0; j < n; j++) step();
      end
      run_idle(2000);

      // Reset during XFER of MOVE_BA with two commands queued behind it.
      push_cmd(OP_BA, 5'h00);
      push_cmd(OP_LA, 5'h09);
      push_cmd(OP_LB, 5'h12);
      n = 0;
      while (!in_xfer_ba(0, cyc) && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) begin
         n_tests++;
         n_fail++;
         $error("FAIL xfer_wait: observed %0d cycles, required fewer than 20", n);
      end
      rst = 1'b0;
      #1;
      check_reset_outputs();
      model_reset();
      step();
      rst = 1'b1;

      // Traffic after release, accepted at the first edge.
      push_cmd(OP_LA, 5'h15);
      push_cmd(OP_BA, 5'h01);
      run_idle(100);

      check("done_count", 0, 32'(done_obs[0]), 32'(done_exp[0]));
      check("done_count", 1, 32'(done_obs[1]), 32'(done_exp[1]));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/transfer_ctrl.md
TRANSFER_CTRL -- requirements
Module: transfer_ctrl

Interface
REQ-001 SHALL have parameter CMD_DEPTH, default 4, command FIFO depth (power of 2, >=2).
REQ-002 SHALL have parameter RD_LAT, default 0, file-register read wait cycles before load (0..3).
REQ-003 SHALL have parameter TURN_CYC, default 1, bus-idle turnaround cycles after each bus drive (1..3).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid  input  1  command offered.
REQ-007 SHALL have port cmd_ready  output  1  FIFO can accept a command.
REQ-008 SHALL have port cmd_op  input  2  opcode: 0 LOAD_A, 1 LOAD_B, 2 MOVE_AB, 3 MOVE_BA.
REQ-009 SHALL have port cmd_addr  input  5  file-register read address, used by LOAD ops only.
REQ-010 SHALL have port DataA  output  5  file-register read address, port 1.
REQ-011 SHALL have port DataB  output  5  file-register read address, port 2.
REQ-012 SHALL have ports SEL_A and SEL_B  output  1 each  register input select: 1 = file-register data, 0 = shared bus.
REQ-013 SHALL have ports LD_A and LD_B  output  1 each  register load enables.
REQ-014 SHALL have ports OEA and OEB  output  1 each  tristate bus drive enables.
REQ-015 SHALL have port busy  output  1  FSM not in IDLE, or FIFO not empty.
REQ-016 SHALL have port done  output  1  one-cycle pulse at command completion.

Function
REQ-017 SHALL push {cmd_op, cmd_addr} into the FIFO on each edge where cmd_valid && cmd_ready.
REQ-018 SHALL drive cmd_ready = !full; a pop in the same cycle SHALL NOT raise cmd_ready while full.
REQ-019 SHALL use FSM states IDLE, RDWAIT, LOAD, DRIVE, XFER, TURN.
REQ-020 SHALL transition from IDLE, when the FIFO is non-empty, by popping the head into a current-command register at the next edge and entering RDWAIT for a LOAD with RD_LAT>0, LOAD for a LOAD with RD_LAT=0, or DRIVE for a MOVE.
REQ-021 SHALL stay in RDWAIT for exactly RD_LAT cycles, then go to LOAD.
REQ-022 For LOAD_A, in both RDWAIT and LOAD, SHALL drive DataA=addr and SEL_A=1; in LOAD SHALL drive LD_A=1 and done=1, then return to IDLE. LOAD_B is identical on DataB/SEL_B/LD_B.
REQ-023 For MOVE_AB, SHALL drive OEA=1 and SEL_B=0 in DRIVE (1 cycle), OEA=1, SEL_B=0 and LD_B=1 in XFER (1 cycle), then all OE=0 in TURN for TURN_CYC cycles, with done=1 in the last TURN cycle. MOVE_BA mirrors this (OEB, SEL_A, LD_A).
REQ-024 SHALL decode all control outputs from the state and current-command registers only, never from cmd_* inputs.
REQ-025 SHALL never assert OEA and OEB in the same cycle.
REQ-026 SHALL assert an OE only in DRIVE or XFER, and SHALL deassert it for at least TURN_CYC cycles before any other OE rises.
REQ-027 SHALL never assert LD_A and LD_B in the same cycle.
REQ-028 SHALL drive every control output not named for the current state to 0, with DataA/DataB=0.
REQ-029 SHALL return from IDLE straight into the next command with no idle gap when the FIFO is non-empty at completion: IDLE lasts exactly 1 cycle.
REQ-030 SHALL give a LOAD accepted at edge E into an empty, idle block an LD pulse in cycle E+1+RD_LAT (cycles counted after edge E).
REQ-031 SHALL wrap the FIFO pointers modulo CMD_DEPTH and SHALL use an occupancy count of width log2(CMD_DEPTH)+1.

Reset
REQ-032 On rst=0, SHALL immediately, without waiting for clk, force the FSM to IDLE, empty the FIFO, and drive all control outputs, busy and done to 0 and DataA/DataB to 0; cmd_ready SHALL be 1.
REQ-033 A reset mid-command SHALL abandon that command and all queued commands; no done pulse SHALL follow it.
REQ-034 After rst deasserts, SHALL accept a command at the first edge.

Verification
REQ-035 Reset, then LOAD_A addr=5'h0C with RD_LAT=0 -> cycle E+1: DataA=0C, SEL_A=1, LD_A=1, done=1; E+2: all controls 0, busy=0.
REQ-036 MOVE_AB with TURN_CYC=1 -> OEA=1 for 2 cycles, LD_B=1 in the second only, then 1 cycle with OEA=OEB=0 and done=1; OEB stays 0 throughout.
REQ-037 Push 5 commands back-to-back with CMD_DEPTH=4 and FSM busy -> cmd_ready=0 after the 4th accept (the 5th is held off); all 5 execute in order, with exactly 5 done pulses.
REQ-038 Alternate MOVE_AB and MOVE_BA 8 times with TURN_CYC=2 -> an assertion check shows OEA&OEB never 1 and at least 2 idle-bus cycles between drives.
REQ-039 Assert rst during XFER of MOVE_BA with 2 commands queued -> OEB and LD_A drop before the next clk edge, with no done; after release busy=0 and cmd_ready=1.
REQ-040 LOAD_B addr=5'h1F with RD_LAT=2 -> DataB=1F and SEL_B=1 for 3 cycles, LD_B=1 in the 3rd only.
